// File: rtl/result_display_if.sv
// Result-display bus: load/value request, busy status and the multiplexed 7-segment drive.
interface result_display_if;
  logic        load;
  logic [15:0] value;
  logic        busy;
  logic        OVF;
  logic [7:0]  SEG;
  logic [3:0]  AN;

  modport master (output load, value, input busy, OVF, SEG, AN);
  modport slave  (input load, value, output busy, OVF, SEG, AN);
endinterface

// File: rtl/result_display.sv
// Binary-to-BCD result display with 4-digit scanned 7-seg drive; LEADING_ZERO_BLANK_EN blanks leading zeros.
// Latency: 16 busy cycles per conversion; a load while busy is dropped, display scanning never stalls.
module result_display #(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input logic             Clock,
  input logic             Reset,
  result_display_if.slave bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  state_t      state_q;
  logic        busy_q;
  logic        ovf_q;
  logic [15:0] digits_q;
  logic [15:0] sr_q;
  logic [19:0] bcd_q;
  logic [4:0]  cnt_q;

  logic [19:0] bcd_adj;
  logic [19:0] bcd_d;
  logic [15:0] sr_d;

  logic [15:0] presc_q;
  logic [1:0]  idx_q;

  logic [3:0]  digit;
  logic        lead_blank;
  logic [7:0]  seg_d;

  // One double-dabble step: correct nibbles >=5, then shift the whole chain left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    {bcd_d, sr_d} = {bcd_adj, sr_q} << 1;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      digits_q <= 16'h0000;
      sr_q     <= 16'h0000;
      bcd_q    <= 20'h00000;
      cnt_q    <= 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.load) begin
            sr_q    <= bus.value;
            bcd_q   <= 20'h00000;
            cnt_q   <= 5'd0;
            state_q <= S_CONV;
            busy_q  <= 1'b1;
          end
        end
        S_CONV: begin
          sr_q  <= sr_d;
          bcd_q <= bcd_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            digits_q <= bcd_d[15:0];
            ovf_q    <= |bcd_d[19:16];
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Scan timing is free-running and deliberately decoupled from the converter.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      presc_q <= 16'd0;
      idx_q   <= 2'd0;
    end else if (presc_q == SCAN_DIV - 16'd1) begin
      presc_q <= 16'd0;
      idx_q   <= idx_q + 2'd1;
    end else begin
      presc_q <= presc_q + 16'd1;
    end
  end

  always_comb begin
    digit      = digits_q[{idx_q, 2'b00} +: 4];
    lead_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (idx_q)
      2'd3:    lead_blank = (digits_q[15:12] == 4'd0);
      2'd2:    lead_blank = (digits_q[15:8] == 8'd0);
      2'd1:    lead_blank = (digits_q[15:4] == 12'd0);
      default: lead_blank = 1'b0;
    endcase
`endif
    case (digit)
      4'd0:    seg_d = 8'hC0;
      4'd1:    seg_d = 8'hF9;
      4'd2:    seg_d = 8'hA4;
      4'd3:    seg_d = 8'hB0;
      4'd4:    seg_d = 8'h99;
      4'd5:    seg_d = 8'h92;
      4'd6:    seg_d = 8'h82;
      4'd7:    seg_d = 8'hF8;
      4'd8:    seg_d = 8'h80;
      4'd9:    seg_d = 8'h90;
      default: seg_d = 8'hFF;
    endcase
    if (lead_blank) begin
      seg_d = 8'hFF;
    end
    if (ovf_q) begin
      seg_d = 8'hBF;
    end
  end

  assign bus.AN   = ~(4'b0001 << idx_q);
  assign bus.SEG  = seg_d;
  assign bus.busy = busy_q;
  assign bus.OVF  = ovf_q;

endmodule

// File: tb/tb_result_display.sv
// Randomized bench for result_display against a decimal-arithmetic display model.
module tb_result_display;
  localparam int SD = 4;
  localparam logic [7:0] SEG_TBL [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  result_display_if bus ();
  result_display #(.SCAN_DIV(16'd4)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc;
  int shown_val;
  bit shown_ovf;

  // Cycles since reset release; the selected digit is purely a function of elapsed time.
  always @(posedge Clock or negedge Reset) begin
    if (!Reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int val, input bit ovf, input int idx);
    int p = 1;
    for (int k = 0; k < idx; k++) p *= 10;
    if (ovf) return 8'hBF;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && (val % 10000) < p) return 8'hFF;
`endif
    return SEG_TBL[(val / p) % 10];
  endfunction

  task automatic check_display(input string tag);
    int idx = (cyc / SD) % 4;
    logic [3:0] e_an = ~(4'b0001 << idx);
    check({tag, "_AN"}, bus.AN, e_an);
    check({tag, "_SEG"}, bus.SEG, exp_seg(shown_val, shown_ovf, idx));
    check({tag, "_OVF"}, bus.OVF, shown_ovf);
  endtask

  task automatic run_display(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      check_display("scan");
      check("idle_busy", bus.busy, 0);
    end
  endtask

  // inj_cycle: busy cycle on which a second load is attempted; rst_cycle: busy cycle to reset on.
  task automatic convert(input int v, input int inj_cycle, input int inj_val, input int rst_cycle);
    int n = 0;
    bit aborted = 0;
    @(negedge Clock);
    bus.load  = 1'b1;
    bus.value = v[15:0];
    @(negedge Clock);
    bus.load = 1'b0;
    while (bus.busy && n < 100 && !aborted) begin
      n++;
      check_display("hold");
      if (n == rst_cycle) begin
        Reset = 1'b0;
        #1;
        shown_val = 0;
        shown_ovf = 0;
        check("rst_busy", bus.busy, 0);
        check_display("rst");
        aborted = 1;
      end else begin
        if (n == inj_cycle) begin
          bus.load  = 1'b1;
          bus.value = inj_val[15:0];
        end else begin
          bus.load = 1'b0;
        end
        @(negedge Clock);
      end
    end
    bus.load = 1'b0;
    if (!aborted) begin
      check("busy_len", n, 16);
      shown_val = v;
      shown_ovf = (v > 9999);
      check_display("done");
    end
  endtask

  initial begin
    Reset     = 1'b0;
    bus.load  = 1'b0;
    bus.value = 16'h0000;
    shown_val = 0;
    shown_ovf = 0;
    #12;
    check("reset_AN", bus.AN, 4'b1110);
    check("reset_SEG", bus.SEG, 8'hC0);
    check("reset_busy", bus.busy, 0);
    check("reset_OVF", bus.OVF, 0);
    @(negedge Clock);
    Reset = 1'b1;
    run_display(8);

    convert(1234, 0, 0, 0);
    run_display(16);
    convert(9999, 0, 0, 0);
    run_display(16);
    convert(10000, 0, 0, 0);
    run_display(16);
    convert(42, 5, 7, 0);
    run_display(16);
    convert(0, 0, 0, 0);
    run_display(16);
    convert(7, 0, 0, 0);
    run_display(16);
    convert(65535, 0, 0, 0);
    run_display(8);

    for (int i = 0; i < 16; i++) begin
      int v = (i % 2 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 65535));
      convert(v, 0, 0, 0);
      run_display(6);
    end

    convert(1234, 0, 0, 0);
    run_display(8);
    convert(5555, 0, 0, 8);
    @(negedge Clock);
    Reset = 1'b1;
    run_display(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
